// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of the asynchronous sig_in over back-to-back
// gate windows of GATE_CYCLES clocks and publishes each count with a strobe.
module freq_meter #(
   parameter int unsigned GATE_CYCLES = 50000000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             freq_valid,
   output logic             overflow,
   output logic             gate,
   output logic [7:0]       led
);
   localparam int unsigned      GW        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           state, state_next;
   logic             s1, s2, s3;
   logic             sig_rise;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic             sat;
   logic             counting;
   logic             last_cycle;
   logic             cnt_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sig_rise = s2 & ~s3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      counting   = 1'b0;
      case (state)
         IDLE:    if (en) state_next = MEASURE;
         MEASURE: begin
            if (!en) state_next = IDLE;
            else     counting   = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign last_cycle = counting && (gate_cnt == GATE_LAST);
   assign cnt_full   = (edge_cnt == CNT_MAX);
   assign gate       = (state == MEASURE);

   // The last window cycle folds its own edge into the published count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         sat        <= 1'b0;
         freq       <= '0;
         freq_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         freq_valid <= 1'b0;
         if (last_cycle) begin
            freq       <= (sig_rise && !cnt_full) ? edge_cnt + CNT_W'(1) : edge_cnt;
            overflow   <= sat | (sig_rise & cnt_full);
            freq_valid <= 1'b1;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
         end else if (counting) begin
            gate_cnt <= gate_cnt + GW'(1);
            if (sig_rise) begin
               if (cnt_full) sat      <= 1'b1;
               else          edge_cnt <= edge_cnt + CNT_W'(1);
            end
         end else begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
         end
      end
   end

   generate
      if (CNT_W >= 8) begin : g_led_wide
         assign led = freq[7:0];
      end else begin : g_led_narrow
         assign led = {{(8 - CNT_W){1'b0}}, freq};
      end
   endgenerate

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (8-bit and 2-bit counters) share one
// stimulus and are checked against a window/edge-history reference model.
module tb_freq_meter;
   localparam int GATE = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       sig_in;
   logic [7:0] freq8, led8;
   logic [1:0] freq2;
   logic [7:0] led2;
   logic       fv8, ov8, gate8;
   logic       fv2, ov2, gate2;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   bit samp[$];
   bit measuring;
   int wcnt, ecount;
   int exp_f8, exp_f2;
   bit exp_ov8, exp_ov2, exp_valid;

   always #5 clk = ~clk;

   freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8)) dut_w8 (
      .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
      .freq(freq8), .freq_valid(fv8), .overflow(ov8), .gate(gate8), .led(led8)
   );

   freq_meter #(.GATE_CYCLES(GATE), .CNT_W(2)) dut_w2 (
      .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
      .freq(freq2), .freq_valid(fv2), .overflow(ov2), .gate(gate2), .led(led2)
   );

   task automatic model_reset();
      samp.delete();
      measuring = 1'b0;
      wcnt      = 0;
      ecount    = 0;
      exp_f8    = 0;
      exp_f2    = 0;
      exp_ov8   = 1'b0;
      exp_ov2   = 1'b0;
      exp_valid = 1'b0;
   endtask

   // A rise seen at sample j is counted at clock edge j+2.
   task automatic model_edge();
      int n;
      bit a, b, rise;
      samp.push_back(sig_in);
      n = samp.size() - 1;
      a = (n >= 2) ? samp[n-2] : 1'b0;
      b = (n >= 3) ? samp[n-3] : 1'b0;
      rise = a && !b;
      exp_valid = 1'b0;
      if (!measuring) begin
         if (en) begin
            measuring = 1'b1;
            wcnt      = 0;
            ecount    = 0;
         end
      end else if (!en) begin
         measuring = 1'b0;
      end else begin
         wcnt++;
         if (rise) ecount++;
         if (wcnt == GATE) begin
            exp_f8    = (ecount > 255) ? 255 : ecount;
            exp_ov8   = (ecount > 255);
            exp_f2    = (ecount > 3) ? 3 : ecount;
            exp_ov2   = (ecount > 3);
            exp_valid = 1'b1;
            wcnt      = 0;
            ecount    = 0;
         end
      end
   endtask

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ":fv8"},   32'(fv8),   32'(exp_valid));
      chk({tag, ":fv2"},   32'(fv2),   32'(exp_valid));
      chk({tag, ":gate8"}, 32'(gate8), 32'(measuring));
      chk({tag, ":gate2"}, 32'(gate2), 32'(measuring));
      chk({tag, ":freq8"}, 32'(freq8), 32'(exp_f8));
      chk({tag, ":freq2"}, 32'(freq2), 32'(exp_f2));
      chk({tag, ":ov8"},   32'(ov8),   32'(exp_ov8));
      chk({tag, ":ov2"},   32'(ov2),   32'(exp_ov2));
      chk({tag, ":led8"},  32'(led8),  32'(exp_f8));
      chk({tag, ":led2"},  32'(led2),  32'(exp_f2));
   endtask

   task automatic step(string tag);
      @(posedge clk);
      if (!reset) model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      step("in_reset");
      step("in_reset");
      reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      en     = 1'b0;
      sig_in = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all("reset");
      reset = 1'b0;

      for (int i = 0; i < 40; i++) step("idle");

      en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         sig_in = ((i / 2) % 2) == 1;
         step("period4");
      end

      for (int i = 0; i < 40; i++) begin
         sig_in = ~sig_in;
         step("period2");
      end
      sig_in = 1'b0;
      for (int i = 0; i < 40; i++) step("constant");

      for (int i = 0; i < 40; i++) begin
         sig_in = ((i / 2) % 2) == 1;
         step("period4b");
      end
      for (int i = 0; i < 4 * GATE && wcnt != 8; i++) begin
         sig_in = ~sig_in;
         step("to_mid");
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) step("en_drop");
      en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         sig_in = ((i / 2) % 2) == 1;
         step("reenable");
      end

      sig_in = 1'b0;
      for (int i = 0; i < 4 * GATE && wcnt != 2; i++) step("to_single");
      sig_in = 1'b1;
      step("single");
      step("single");
      sig_in = 1'b0;
      for (int i = 0; i < 20; i++) step("single_tail");

      for (int i = 0; i < 4 * GATE && wcnt != 8; i++) begin
         sig_in = ((i / 2) % 2) == 1;
         step("pre_reset");
      end
      pulse_reset();
      for (int i = 0; i < 40; i++) begin
         sig_in = ((i / 2) % 2) == 1;
         step("post_reset");
      end

      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 2) != 0) sig_in = $urandom_range(0, 1) == 1;
         en = $urandom_range(0, 63) != 0;
         if ($urandom_range(0, 299) == 0) pulse_reset();
         else step("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the frequency of an asynchronous input signal. It counts rising edges of `sig_in` over a fixed gate window of `GATE_CYCLES` clock cycles, then publishes the count with a one-cycle valid strobe. It is the input-side counterpart of the 50 MHz one-second tick/LED blinker: with the default window of 50,000,000 cycles at 50 MHz, `freq` reads directly in Hz. The low byte drives the board LEDs.

## Interface
- `GATE_CYCLES`, default 50000000. Window length in clk cycles; must be ≥ 2.
- `CNT_W`, default 32. Width of the edge counter and of `freq`.
- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  reset, asynchronous, active-high; clock clk.
- `en`  in  1  measurement enable; synchronous, level.
- `sig_in`  in  1  signal under test; asynchronous to clk.
- `freq`  out  CNT_W  rising-edge count of the last completed window.
- `freq_valid`  out  1  one-cycle strobe, high when `freq` has just been updated.
- `overflow`  out  1  last completed window saturated the edge counter.
- `gate`  out  1  high while a window is open (state MEASURE).
- `led`  out  8  equals `freq[7:0]`; zero-extend `freq` if `CNT_W` < 8.

## Operation
- Synchroniser: `s1 <= sig_in`, `s2 <= s1`, `s3 <= s2`, all reset to 0.
  - `edge = s2 & ~s3`.
  - If `sig_in` is high at reset release, that counts as one rising edge.
- FSM has two states, reset state IDLE.
  - IDLE: `gate_cnt` = 0, `edge_cnt` = 0, edges ignored. When `en` = 1, go to MEASURE.
  - MEASURE, `en` = 0: return to IDLE. The partial window is discarded: no strobe, and `freq`/`overflow` keep their old values.
  - MEASURE, `en` = 1, `gate_cnt` < GATE_CYCLES-1:
    - `gate_cnt` increments.
    - On `edge`, `edge_cnt` increments, saturating at 2^CNT_W-1.
    - `sat` flag sets if an increment is attempted while `edge_cnt` is already at maximum.
  - MEASURE, `en` = 1, `gate_cnt` = GATE_CYCLES-1 (last window cycle):
    - `freq <= sat_add(edge_cnt, edge)`.
    - `overflow <=` `sat`, or 1 if this cycle's edge would also overflow.
    - `freq_valid <= 1`.
    - `gate_cnt`, `edge_cnt` and `sat` clear to 0; the FSM stays in MEASURE.
    - Windows therefore run back-to-back with no dead cycle. An edge on the last cycle belongs to the ending window.
- `freq_valid` is 0 in every other cycle.
- `gate` = 1 exactly in MEASURE.
- Counter widths:
  - `gate_cnt` is wide enough to hold GATE_CYCLES-1 (32 bits is sufficient for the default).
  - `edge_cnt` is CNT_W bits.
  - All comparisons are unsigned.

## Timing
- Reset values:
  - `freq` = 0, `freq_valid` = 0, `overflow` = 0, `gate` = 0, `led` = 0.
  - FSM in IDLE; all counters and synchroniser flops at 0.
- Reset asserted mid-window: all outputs are 0 immediately (asynchronous) and no strobe is produced.
- `en` is sampled at rising edge k (FSM leaves IDLE) → `gate` = 1 from cycle k+1. The window is cycles k+1 … k+GATE_CYCLES.
- `freq_valid` is high in cycle k+GATE_CYCLES+1, then every GATE_CYCLES cycles while `en` stays 1.
- `freq`, `overflow` and `led` change only in the cycle `freq_valid` goes high, and hold until the next strobe.
- Latency from a `sig_in` rise to its being counted: 2–3 clk (synchroniser). An edge arriving within the last 2–3 cycles of a window is counted in the next window.
- Maximum countable rate: 1 edge per 2 clk, i.e. at most GATE_CYCLES/2 edges per window.

## Test plan
Benches use `GATE_CYCLES` = 16 unless noted.
1. Reset with `en` = 0, `sig_in` = 0 → all outputs 0. Hold 40 cycles → `freq_valid` never asserts, `gate` = 0.
2. `CNT_W` = 8. Raise `en`; `sig_in` toggles every 2 clk (period 4) → `freq_valid` pulses every 16 cycles, first at en-sample + 17. `freq` = 4, `led` = 8'h04, `overflow` = 0.
3. `sig_in` toggles every clk (period 2) → `freq` = 8. Then hold `sig_in` constant → next full window gives `freq` = 0 and `freq_valid` still pulses.
4. Drop `en` 8 cycles into a window → `gate` falls next cycle, no strobe, `freq` holds its previous value (4). Re-raise `en` → a fresh full 16-cycle window; strobe with `freq` = 4.
5. `CNT_W` = 2, period-4 input (4 edges) → `freq` = 3, `overflow` = 1. Next window with exactly 1 edge → `freq` = 1, `overflow` = 0.
6. Assert `reset` mid-window while `freq` = 4 → `freq`, `led`, `gate` and `freq_valid` go to 0 immediately. After release with `en` = 1, the first strobe occurs 17 cycles after the FSM first samples `en`.
